uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of byte requesters sharing one UART transmitter; legal range 2..8.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid_i  input  N_REQ  per-requester byte-pending flag; bit i belongs to requester i.
REQ-005 req_data_i  input  8*N_REQ  requester i byte on bits [8*i+7:8*i].
REQ-006 req_ack_o  output  N_REQ  one-cycle pulse; byte of requester i consumed.
REQ-007 tx_din_o  output  8  byte presented to the transmitter.
REQ-008 tx_start_o  output  1  one-cycle transmit strobe.
REQ-009 tx_done_tick_i  input  1  one-cycle end-of-frame pulse from the transmitter.
REQ-010 busy_o  output  1  high in every state except S_IDLE.
REQ-011 grant_id_o  output  3  index of the requester being served; holds its value while in S_IDLE.

Function
REQ-012 The FSM SHALL use states S_IDLE, S_START, S_WAIT, plus S_TAG_START and S_TAG_WAIT when the tag feature is compiled in.
REQ-013 In S_IDLE with any req_valid_i bit set, the block SHALL grant by round-robin, searching from (last_grant+1) mod N_REQ upward with wrap-around.
REQ-014 On grant, the block SHALL:
- latch the granted byte into tx_din_o;
- set grant_id_o;
- pulse req_ack_o for the granted bit only, in the same cycle as the grant decision;
- move to S_START, or to S_TAG_START per REQ-023.
REQ-015 S_START SHALL assert tx_start_o for exactly one cycle, then go to S_WAIT.
REQ-016 S_WAIT SHALL hold tx_din_o stable and return to S_IDLE on tx_done_tick_i; it SHALL update last_grant to grant_id_o on that same edge.
REQ-017 The earliest next tx_start_o SHALL come 2 cycles after a tx_done_tick_i (S_IDLE, then S_START), so the transmitter is back in idle.
REQ-018 A tx_done_tick_i outside S_WAIT or S_TAG_WAIT SHALL be ignored.
REQ-019 req_valid_i dropping after its ack SHALL have no effect on the frame in flight; a requester not granted SHALL see no ack.
REQ-020 The block SHALL issue at most one ack per grant and never more than one req_ack_o bit at a time.
REQ-021 No timeout exists; S_WAIT SHALL wait indefinitely for tx_done_tick_i.

Reset
REQ-022 While rst_n is low at a clk edge, the block SHALL force:
- state to S_IDLE;
- tx_start_o, req_ack_o, busy_o and tx_din_o to 0;
- grant_id_o and last_grant to N_REQ-1, so requester 0 wins first;
- last_tagged to invalid.
Reset mid-frame SHALL abandon the frame without an ack.

Configuration
REQ-023 With macro UART_TX_ARB_TAG_EN defined:
- a grant whose id differs from last_tagged (or with last_tagged invalid) SHALL first send tag byte 8'hA0 | id via S_TAG_START (one-cycle tx_start_o) and S_TAG_WAIT (wait tx_done_tick_i);
- the block SHALL then go to S_START with the data byte, and set last_tagged to id;
- the ack SHALL still pulse at grant time.
Without the macro, the tag states, last_tagged and the tag logic SHALL be absent, and every grant SHALL go directly to S_START.

Verification
REQ-024 Reset, then req_valid_i=4'b0001 with byte 8'h55 -> ack[0] pulse, tx_din_o=8'h55, tx_start_o one cycle later, busy_o high until done.
REQ-025 req_valid_i=4'b1111 held continuously with a done tick returned for every frame -> grant order 0,1,2,3,0; each frame's start exactly 2 cycles after the previous done.
REQ-026 req_valid_i=4'b0100 and 4'b0001 asserted together with last_grant=1 -> requester 2 served first, requester 0 second.
REQ-027 rst_n low for one cycle while in S_WAIT -> tx_start_o=0, busy_o=0, grant_id_o=N_REQ-1 next cycle; a spurious done tick afterwards causes no ack.
REQ-028 With UART_TX_ARB_TAG_EN defined, requester 3 sends byte 8'h41 twice -> bytes 8'hA3, 8'h41, 8'h41 on tx_din_o; a following requester 1 byte 8'h42 -> bytes 8'hA1, 8'h42.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmitter between N_REQ byte requesters using
//   round-robin arbitration. A granted byte is acknowledged immediately.
//   It is then presented on tx_din_o with a one-cycle tx_start_o strobe.
//   The block holds the byte until the transmitter reports tx_done_tick_i.
//
//   Optional feature (macro UART_TX_ARB_TAG_EN): when the granted requester
//   differs from the last one tagged, a tag byte 8'hA0 | id is sent first.
//
// Ports
//   clk             clock, rising edge
//   rst_n           synchronous active-low reset
//   req_valid_i     per-requester byte-pending flags
//   req_data_i      requester i byte on [8*i+7:8*i]
//   req_ack_o       one-cycle pulse, byte of requester i consumed
//   tx_din_o        byte presented to the transmitter
//   tx_start_o      one-cycle transmit strobe
//   tx_done_tick_i  end-of-frame pulse from the transmitter
//   busy_o          high whenever not idle
//   grant_id_o      index of the requester being served
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    output logic [N_REQ-1:0]   req_ack_o,
    output logic [7:0]         tx_din_o,
    output logic               tx_start_o,
    input  logic               tx_done_tick_i,
    output logic               busy_o,
    output logic [2:0]         grant_id_o
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT      = 3'd2;
`ifdef UART_TX_ARB_TAG_EN
    localparam logic [2:0] S_TAG_START = 3'd3;
    localparam logic [2:0] S_TAG_WAIT  = 3'd4;
`endif

    localparam logic [2:0]       ID_RST = 3'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE    = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [2:0] state_q, state_d;
    logic [7:0] tx_din_q, tx_din_d;
    logic [2:0] grant_q, grant_d;
    logic [2:0] last_grant_q, last_grant_d;
`ifdef UART_TX_ARB_TAG_EN
    logic [7:0] data_q, data_d;
    logic [2:0] last_tag_q, last_tag_d;
    logic       last_tag_vld_q, last_tag_vld_d;
`endif

    // Inputs are zero-extended to the 8-requester maximum.
    // This lets a 3-bit index address them without width mismatches.
    logic [7:0]  valid_ext;
    logic [63:0] data_ext;
    logic        pick_found;
    logic [2:0]  pick_idx;
    logic [7:0]  pick_byte;
    logic        grant_fire;

    assign valid_ext = 8'(req_valid_i);
    assign data_ext  = 64'(req_data_i);

    // Round-robin search from last_grant+1 with wrap-around.
    // The loop visits offsets from farthest to nearest.
    // The last hit therefore is the nearest requester.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (valid_ext[3'((32'(last_grant_q) + N_REQ - k) % N_REQ)]) begin
                pick_found = 1'b1;
                pick_idx   = 3'((32'(last_grant_q) + N_REQ - k) % N_REQ);
            end
        end
    end

    assign pick_byte  = data_ext[{pick_idx, 3'b000} +: 8];
    assign grant_fire = rst_n && (state_q == S_IDLE) && pick_found;

    // The ack is issued combinationally in the cycle the grant is decided.
    assign req_ack_o = grant_fire ? (ONE << pick_idx) : '0;

    always_comb begin
        state_d      = state_q;
        tx_din_d     = tx_din_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
`ifdef UART_TX_ARB_TAG_EN
        data_d         = data_q;
        last_tag_d     = last_tag_q;
        last_tag_vld_d = last_tag_vld_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d  = pick_idx;
                    tx_din_d = pick_byte;
                    state_d  = S_START;
`ifdef UART_TX_ARB_TAG_EN
                    // Keep the data byte aside while the tag byte occupies tx_din.
                    data_d = pick_byte;
                    if (!last_tag_vld_q || (last_tag_q != pick_idx)) begin
                        tx_din_d = {5'b10100, pick_idx};
                        state_d  = S_TAG_START;
                    end
`endif
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (tx_done_tick_i) begin
                    state_d      = S_IDLE;
                    last_grant_d = grant_q;
                end
            end
`ifdef UART_TX_ARB_TAG_EN
            S_TAG_START: state_d = S_TAG_WAIT;
            S_TAG_WAIT: begin
                if (tx_done_tick_i) begin
                    state_d        = S_START;
                    tx_din_d       = data_q;
                    last_tag_d     = grant_q;
                    last_tag_vld_d = 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tx_din_q     <= '0;
            grant_q      <= ID_RST;
            last_grant_q <= ID_RST;
`ifdef UART_TX_ARB_TAG_EN
            data_q         <= '0;
            last_tag_q     <= '0;
            last_tag_vld_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            tx_din_q     <= tx_din_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
`ifdef UART_TX_ARB_TAG_EN
            data_q         <= data_d;
            last_tag_q     <= last_tag_d;
            last_tag_vld_q <= last_tag_vld_d;
`endif
        end
    end

`ifdef UART_TX_ARB_TAG_EN
    assign tx_start_o = (state_q == S_START) || (state_q == S_TAG_START);
`else
    assign tx_start_o = (state_q == S_START);
`endif
    assign busy_o     = (state_q != S_IDLE);
    assign tx_din_o   = tx_din_q;
    assign grant_id_o = grant_q;

endmodule
